// File: rtl/beam_thresh_loader.sv
// Per-beam threshold shadow bank with a sequenced commit: one beam per cycle on a shared bus,
// then a common update strobe. Optional readback port set enabled by BEAM_THRESH_READBACK_EN.
module beam_thresh_loader #(
  parameter int unsigned NBEAMS         = 2,
  parameter logic [17:0] DEFAULT_THRESH = 18'd4095,
  parameter bit          LOAD_ON_RESET  = 1'b1,
  parameter int unsigned AW             = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic              wr_all_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [17:0]       wr_data_i,
  input  logic              commit_i,
  output logic [17:0]       thresh_o,
  output logic [NBEAMS-1:0] thresh_ce_o,
  output logic              update_o,
  output logic              busy_o,
  output logic              done_o
`ifdef BEAM_THRESH_READBACK_EN
  ,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [17:0]       rd_data_o,
  output logic [NBEAMS-1:0] loaded_o
`endif
);

  localparam int unsigned IW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NBEAMS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StUpdate} state_e;

  state_e            state, state_next;
  logic [IW-1:0]     idx, idx_next;
  logic              pending, pending_next;
  logic              auto_commit;
  logic [17:0]       shadow [NBEAMS];
  logic [NBEAMS-1:0] wr_hit;
  logic [NBEAMS-1:0] ce_next;
  logic [17:0]       sel_thresh;

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < int'(NBEAMS); k++) begin
      wr_hit[k] = wr_i & (wr_all_i | (wr_addr_i == AW'(k)));
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    pending_next = pending;
    case (state)
      StIdle: begin
        if (commit_i || auto_commit) begin
          state_next = StLoad;
          idx_next   = '0;
        end
      end
      StLoad: begin
        pending_next = pending | commit_i;
        if (idx == LastIdx) begin
          state_next = StUpdate;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      StUpdate: begin
        // A commit landing in the update cycle chains straight into the next pass.
        pending_next = 1'b0;
        if (pending || commit_i) begin
          state_next = StLoad;
          idx_next   = '0;
        end else begin
          state_next = StIdle;
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  // Bus value and CE are selected from the pre-write shadow for the beam loaded on this edge.
  always_comb begin
    sel_thresh = '0;
    ce_next    = '0;
    for (int k = 0; k < int'(NBEAMS); k++) begin
      if (idx_next == IW'(k)) begin
        sel_thresh = shadow[k];
        ce_next[k] = (state_next == StLoad);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      idx         <= '0;
      pending     <= 1'b0;
      auto_commit <= LOAD_ON_RESET;
      thresh_o    <= '0;
      thresh_ce_o <= '0;
      update_o    <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      for (int k = 0; k < int'(NBEAMS); k++) begin
        shadow[k] <= DEFAULT_THRESH;
      end
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      pending     <= pending_next;
      auto_commit <= 1'b0;
      thresh_ce_o <= ce_next;
      update_o    <= (state_next == StUpdate);
      done_o      <= (state_next == StUpdate);
      busy_o      <= (state_next != StIdle);
      if (state_next == StLoad) begin
        thresh_o <= sel_thresh;
      end
      for (int k = 0; k < int'(NBEAMS); k++) begin
        if (wr_hit[k]) begin
          shadow[k] <= wr_data_i;
        end
      end
    end
  end

`ifdef BEAM_THRESH_READBACK_EN
  logic [17:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < int'(NBEAMS); k++) begin
      if (rd_addr_i == AW'(k)) begin
        rd_sel = shadow[k];
      end
    end
  end

  // A write to a beam invalidates its loaded flag even if it is being loaded on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
      loaded_o  <= '0;
    end else begin
      rd_data_o <= rd_sel;
      loaded_o  <= (loaded_o | ce_next) & ~wr_hit;
    end
  end
`endif

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Scoreboard bench for beam_thresh_loader (NBEAMS=4, AW=3 so out-of-range addresses are reachable).
module tb_beam_thresh_loader;

  localparam int NB = 4;
  localparam int AW = 3;
  localparam logic [17:0] DEF = 18'd4095;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic          wr_all = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [17:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic [17:0]   thresh;
  logic [NB-1:0] ce;
  logic          update, busy, done;
`ifdef BEAM_THRESH_READBACK_EN
  logic [AW-1:0] rd_addr = '0;
  logic [17:0]   rd_data;
  logic [NB-1:0] loaded;
`endif

  beam_thresh_loader #(
    .NBEAMS(NB),
    .DEFAULT_THRESH(DEF),
    .LOAD_ON_RESET(1'b1),
    .AW(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wr_i(wr),
    .wr_all_i(wr_all),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .commit_i(commit),
    .thresh_o(thresh),
    .thresh_ce_o(ce),
    .update_o(update),
    .busy_o(busy),
    .done_o(done)
`ifdef BEAM_THRESH_READBACK_EN
    ,
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .loaded_o(loaded)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          upd;
    int          beam;
    logic [17:0] thr;
  } exp_t;

  exp_t        sbq[$];
  int          starts[$];  // first cycle of each scheduled pass
  logic [17:0] mshadow[NB];
  bit          auto_c, exp_zero, exp_busy, armed;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a pass starting in cycle s shows beam k in cycle s+k and the update in s+NB;
  // each beam value is the shadow content just before the edge that launches it.
  always @(posedge clk) begin : model
    int t;
    bit c;
    t = cyc;
    if (rst) begin
      armed = 1'b1;
      starts.delete();
      sbq.delete();
      for (int k = 0; k < NB; k++) mshadow[k] = DEF;
      auto_c   = 1'b1;
      exp_zero = 1'b1;
      exp_busy = 1'b0;
    end else begin
      c = commit | auto_c;
      auto_c = 1'b0;
      exp_zero = 1'b0;
      if (c) begin
        if (starts.size() == 0 || t > starts[$] + NB) starts.push_back(t + 1);
        else if (t >= starts[$]) starts.push_back(starts[$] + NB + 1);
      end
      exp_busy = 1'b0;
      foreach (starts[i]) begin
        if (t + 1 >= starts[i] && t + 1 < starts[i] + NB)
          sbq.push_back('{upd: 1'b0, beam: t + 1 - starts[i], thr: mshadow[t + 1 - starts[i]]});
        if (t + 1 == starts[i] + NB) sbq.push_back('{upd: 1'b1, beam: 0, thr: '0});
        if (t + 1 >= starts[i] && t + 1 <= starts[i] + NB) exp_busy = 1'b1;
      end
      while (starts.size() > 0 && starts[0] + NB < t + 1) void'(starts.pop_front());
      if (wr) begin
        for (int k = 0; k < NB; k++)
          if (wr_all || int'(wr_addr) == k) mshadow[k] = wr_data;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed) begin
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("done_vs_update", {31'd0, done}, {31'd0, update});
      if (exp_zero) begin
        check("rst_thresh", {14'd0, thresh}, 32'd0);
        check("rst_ce", {28'd0, ce}, 32'd0);
        check("rst_update", {31'd0, update}, 32'd0);
      end
      if (ce != '0 || update || sbq.size() > 0) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", {27'd0, ce, update}, 32'd0);
        end else begin
          e = sbq.pop_front();
          if (e.upd) begin
            check("update", {31'd0, update}, 32'd1);
            check("ce_during_update", {28'd0, ce}, 32'd0);
          end else begin
            check("ce", {28'd0, ce}, 32'd1 << e.beam);
            check("thresh", {14'd0, thresh}, {14'd0, e.thr});
            check("update_during_load", {31'd0, update}, 32'd0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input int a, input logic [17:0] d, input bit all);
    wr = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    wr_all = all;
    step();
    wr = 1'b0;
    wr_all = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(8);
    for (int i = 0; i < NB; i++) write(i, 18'((i + 1) * 100), 1'b0);
    do_commit();
    idle(7);
    // commits at E, E+2, E+3 (load) and E+5 (update) -> two passes back to back
    do_commit();
    step();
    do_commit();
    do_commit();
    step();
    do_commit();
    idle(12);
    // beam 0 written after its load, beam 3 before its load
    do_commit();
    write(0, 18'd7, 1'b0);
    write(3, 18'd9, 1'b0);
    idle(6);
    do_commit();
    idle(7);
    write(0, 18'h3FFFF, 1'b1);
    do_commit();
    idle(6);
    write(5, 18'd1, 1'b0);
    do_commit();
    idle(7);
    // reset while beam 2 is on the bus
    do_commit();
    idle(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(8);
    repeat (400) begin
      wr      = ($urandom % 4) == 0;
      wr_all  = ($urandom % 8) == 0;
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = 18'($urandom);
      commit  = ($urandom % 6) == 0;
      rst     = ($urandom % 97) == 0;
      step();
    end
    wr = 1'b0;
    wr_all = 1'b0;
    commit = 1'b0;
    rst = 1'b0;
    idle(12);
    check("drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
